// File: rtl/fifo_dma_pkg.sv
// fifo_dma_pkg: shared state/request types and burst-length limits for fifo_dma_responder
package fifo_dma_pkg;
  typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT_DATA, S_PUSH, S_ACK} resp_state_t;
  typedef enum logic [1:0] {REQ_NONE, REQ_SINGLE, REQ_BURST} req_kind_t;
  localparam int BURST_LEN_MIN = 2;
  localparam int BURST_LEN_MAX = 256;
  function automatic req_kind_t req_kind(input logic s, input logic b);
    return b ? REQ_BURST : s ? REQ_SINGLE : REQ_NONE;
  endfunction
endpackage

// File: rtl/fifo_dma_responder.sv
// fifo_dma_responder: serves single/burst DMA requests by reading a FIFO port and streaming the words out
module fifo_dma_responder
  import fifo_dma_pkg::*;
#(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] PERIPH_ADDR = '0,
  parameter int                BURST_LEN   = 8,
  parameter int                CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              req_single,
  input  logic              req_burst,
  output logic              req_ack,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  output logic [DATA_W-1:0] src_data,
  output logic              src_valid,
  input  logic              src_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  words_done
);
  if (BURST_LEN < BURST_LEN_MIN || BURST_LEN > BURST_LEN_MAX) begin : g_bad_len
    $error("BURST_LEN must be within 2..256");
  end
  localparam logic [8:0] BURST_REM = 9'(BURST_LEN);
  resp_state_t       state_q, state_d;
  req_kind_t         kind;
  logic [8:0]        rem_q, rem_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              read_q, read_d, valid_q, valid_d, ack_q, ack_d, busy_q, busy_d;
  always_comb begin
    kind    = req_kind(req_single, req_burst);
    state_d = state_q;
    rem_d   = rem_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (enable && kind != REQ_NONE) begin
        state_d = S_READ;
        rem_d   = kind == REQ_BURST ? BURST_REM : 9'd1;
      end
      S_READ: state_d = avm_waitrequest ? S_READ : S_WAIT_DATA;
      S_WAIT_DATA: if (avm_readdatavalid) begin
        hold_d  = avm_readdata;
        state_d = S_PUSH;
      end
      S_PUSH: if (src_ready) begin
        cnt_d   = cnt_q + CNT_W'(1);
        rem_d   = rem_q - 9'd1;
        state_d = rem_q == 9'd1 ? S_ACK : S_READ;
      end
      S_ACK: state_d = (req_single | req_burst) ? S_ACK : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // outputs are registered copies of the next-state decode
    read_d  = state_d == S_READ;
    valid_d = state_d == S_PUSH;
    ack_d   = state_d == S_ACK;
    busy_d  = state_d != S_IDLE;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      hold_q  <= '0;
      cnt_q   <= '0;
      read_q  <= 1'b0;
      valid_q <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      read_q  <= read_d;
      valid_q <= valid_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end
  assign avm_address = PERIPH_ADDR;
  assign avm_read    = read_q;
  assign src_valid   = valid_q;
  assign src_data    = hold_q;
  assign req_ack     = ack_q;
  assign busy        = busy_q;
  assign words_done  = cnt_q;
endmodule

// File: tb/tb_fifo_dma_responder.sv
// tb_fifo_dma_responder: directed/randomized checks of the DMA responder against a transaction-level model
module tb_fifo_dma_responder;
  localparam int          BL   = 8;
  localparam int          CW   = 4;
  localparam logic [31:0] ADDR = 32'hFF20_0040;
  logic          clk = 1'b0, reset_n = 1'b0, enable = 1'b1;
  logic          req_single = 1'b0, req_burst = 1'b0, req_ack;
  logic [31:0]   avm_address, avm_readdata = '0, src_data;
  logic          avm_read, avm_waitrequest = 1'b0, avm_readdatavalid = 1'b0;
  logic          src_valid, src_ready = 1'b1, busy;
  logic [CW-1:0] words_done;
  int            errors = 0, checks = 0, exp_done = 0;
  fifo_dma_responder #(
    .DATA_W(32), .ADDR_W(32), .PERIPH_ADDR(ADDR), .BURST_LEN(BL), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .req_single(req_single), .req_burst(req_burst), .req_ack(req_ack),
    .avm_address(avm_address), .avm_read(avm_read), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .busy(busy), .words_done(words_done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_quiet(input string tag);
    chk({tag, "_ack"}, req_ack, 0);
    chk({tag, "_read"}, avm_read, 0);
    chk({tag, "_valid"}, src_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, words_done, 0);
    chk({tag, "_data"}, src_data, 0);
  endtask
  // Acts as Avalon slave and stream sink for one request; the model is a queue of words the slave returned.
  task automatic xfer(input logic s, input logic b, input int wt, input int stall, input int en_drop, input int abort_at);
    int n, got, reads, hi, wcnt, scnt, cyc, last_hs;
    logic pend;
    logic [31:0] pd, exp_word;
    logic [31:0] q[$];
    n = b ? BL : 1;
    got = 0; reads = 0; hi = 0; wcnt = wt; scnt = stall; cyc = 0; last_hs = 0; pend = 1'b0; pd = '0;
    req_single = s;
    req_burst  = b;
    while (!req_ack && cyc < 2000 && !(abort_at > 0 && got == abort_at)) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) chk("read_start", avm_read, 1);
      avm_readdatavalid = pend;
      avm_readdata = pend ? pd : $urandom;
      if (pend) q.push_back(pd);
      pend = 1'b0;
      avm_waitrequest = 1'b0;
      if (avm_read) begin
        hi++;
        chk("addr", avm_address, ADDR);
        if (wcnt > 0) begin
          avm_waitrequest = 1'b1;
          wcnt--;
        end else begin
          pd = $urandom;
          pend = 1'b1;
          reads++;
          chk("read_hold", hi, wt + 1);
          hi = 0;
          wcnt = wt;
        end
      end
      src_ready = 1'b1;
      if (src_valid) begin
        exp_word = q.size() > 0 ? q[0] : 32'hDEAD_BEEF;
        chk("src_data", src_data, exp_word);
        chk("no_read_in_push", avm_read, 0);
        if (scnt > 0) begin
          src_ready = 1'b0;
          scnt--;
        end else begin
          if (q.size() > 0) void'(q.pop_front());
          got++;
          exp_done = (exp_done + 1) % (1 << CW);
          last_hs = cyc;
        end
      end
      if (en_drop > 0 && got == en_drop) enable = 1'b0;
    end
    avm_readdatavalid = 1'b0;
    avm_waitrequest = 1'b0;
    src_ready = 1'b1;
    if (abort_at == 0) begin
      chk("ack_rise", req_ack, 1);
      chk("ack_latency", cyc - last_hs, 1);
      chk("words", got, n);
      chk("reads", reads, n);
      chk("words_done", words_done, exp_done);
      repeat ($urandom_range(1, 4)) begin
        @(negedge clk);
        chk("ack_hold", req_ack, 1);
        chk("ack_no_read", avm_read, 0);
      end
      req_single = 1'b0;
      req_burst  = 1'b0;
      @(negedge clk);
      chk("ack_fall", req_ack, 0);
      chk("idle", busy, 0);
      enable = 1'b1;
    end
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk_quiet("reset");
    reset_n = 1'b1;
    @(negedge clk);
    xfer(1'b1, 1'b0, 0, 0, 0, 0);
    xfer(1'b0, 1'b1, 0, 0, 0, 0);
    xfer(1'b1, 1'b1, 0, 5, 0, 0);
    xfer(1'b1, 1'b0, 3, 0, 0, 0);
    enable = 1'b0;
    req_burst = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("en_off_read", avm_read, 0);
      chk("en_off_busy", busy, 0);
    end
    req_burst = 1'b0;
    enable = 1'b1;
    @(negedge clk);
    xfer(1'b0, 1'b1, 1, 2, 2, 0);
    xfer(1'b0, 1'b1, 0, 0, 0, 3);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 chk_quiet("rst_mid");
    exp_done = 0;
    req_burst = 1'b0;
    @(negedge clk);
    avm_readdatavalid = 1'b1;
    avm_readdata = 32'hBAD0_0BAD;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    avm_readdatavalid = 1'b0;
    @(negedge clk);
    chk_quiet("late_rdv");
    xfer(1'b1, 1'b0, 0, 0, 0, 0);
    repeat (17) xfer(1'b1, 1'b0, $urandom_range(0, 2), $urandom_range(0, 1), 0, 0);
    repeat (4) xfer(1'($urandom_range(0, 1)), 1'b1, $urandom_range(0, 2), $urandom_range(0, 3), 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fifo_dma_responder.md
# fifo_dma_responder

FPGA-side responder for the PL330-style peripheral DMA request handshake (`single`/`burst` requests, `ack` return) that the loopback FIFO drives. It consumes a request and performs the matching transfer. Each transfer is one Avalon-MM read per word from the FIFO data port. Read data is forwarded on a valid/ready stream, and the request is then acknowledged with a four-phase `ack`. The block sits in the fabric next to the loopback FIFO and lets the FIFO be exercised without the HPS DMA controller.

## Interface
Parameters:
- `DATA_W`, 32, width of the read data and of the stream output
- `ADDR_W`, 32, Avalon-MM address width
- `PERIPH_ADDR`, 32'h0, fixed byte address of the FIFO data register
- `BURST_LEN`, 8, words per burst request; legal range 2..256
- `CNT_W`, 16, width of the `words_done` counter

Ports:
- `clk` in 1: single clock for the whole block
- `reset_n` in 1: asynchronous assert, active-low reset
- `enable` in 1: when low, new requests are not accepted
- `req_single` in 1: single-word request, level
- `req_burst` in 1: burst request, level
- `req_ack` out 1: acknowledge, four-phase
- `avm_address` out ADDR_W: always `PERIPH_ADDR`
- `avm_read` out 1: read strobe
- `avm_waitrequest` in 1: slave stall
- `avm_readdata` in DATA_W: read data
- `avm_readdatavalid` in 1: read data valid
- `src_data` out DATA_W: stream data
- `src_valid` out 1: stream valid
- `src_ready` in 1: stream ready
- `busy` out 1: high in any state other than IDLE
- `words_done` out CNT_W: count of words delivered; wraps to 0

## Operation
- FSM states: IDLE, READ, WAIT_DATA, PUSH, ACK.
- **IDLE**
  - Requests are sampled only when `enable` is 1.
  - If `req_burst` is 1, load `remaining = BURST_LEN`. Else if `req_single` is 1, load `remaining = 1`. `req_burst` has priority when both are high.
  - Move to READ.
- **READ**
  - `avm_read` = 1, held until a cycle with `avm_waitrequest` = 0.
  - Then move to WAIT_DATA with `avm_read` = 0.
  - Only one outstanding read at a time.
- **WAIT_DATA**
  - On `avm_readdatavalid`, capture `avm_readdata` into a one-entry holding register.
  - Move to PUSH.
- **PUSH**
  - `src_valid` = 1, `src_data` = holding register.
  - On `src_valid & src_ready`: increment `words_done` and decrement `remaining`.
  - If `remaining` was 1, go to ACK; otherwise go to READ.
- **ACK**
  - `req_ack` = 1, held while `req_single | req_burst` is high.
  - When both are low, deassert `req_ack` and go to IDLE.
- `enable` falling mid-transfer does not abort; the current request completes, including the ACK phase.
- `avm_readdatavalid` outside WAIT_DATA is ignored. This covers late data after a reset.
- `remaining` is 9 bits; `BURST_LEN` = 256 must load correctly.
- `words_done` is modulo 2^CNT_W.

## Timing
- Reset values: `req_ack` 0, `avm_read` 0, `src_valid` 0, `busy` 0, `words_done` 0, `src_data` 0, FSM in IDLE.
- A request sampled high in IDLE at edge t gives `avm_read` = 1 from cycle t+1.
- With zero waitrequest, one readdatavalid cycle of read latency and `src_ready` tied high, each word takes 3 cycles (READ, WAIT_DATA, PUSH).
- `req_ack` rises the cycle after the last stream handshake.
- `req_ack` falls the cycle after the requests are sampled low.
- IDLE can accept a new request no earlier than the cycle after `req_ack` falls; there is no back-to-back reuse of a stale request level.
- Reset asserted mid-operation clears all outputs asynchronously. The in-flight read and held data are dropped.
- All outputs are registered.

## Structure
- A shared package `fifo_dma_pkg` holds:
  - the FSM state enum `resp_state_t`
  - the request-kind enum (NONE, SINGLE, BURST)
  - the `BURST_LEN` range-check constants.
- The design is one module with no sub-module. The holding register is too small to warrant one.

## Test plan
- **Single request:** `req_single` = 1, data 32'hA5A5_0001, `src_ready` = 1 → one `avm_read`, one stream beat with 32'hA5A5_0001, `req_ack` = 1 until `req_single` drops, `words_done` = 1.
- **Burst request:** `req_burst` = 1, `BURST_LEN` = 8, slave returns 0..7 → exactly 8 reads, stream 0..7 in order, a single ack phase, `words_done` = 8.
- **Simultaneous requests and back-pressure:** `req_single` and `req_burst` both high → burst served (8 words). With `src_ready` low for 5 cycles in PUSH, `src_data` stays stable and no extra read is issued.
- **Waitrequest:** `avm_waitrequest` high for 3 cycles → `avm_read` held 4 cycles with `avm_address` = `PERIPH_ADDR`, one read counted.
- **Enable and reset:**
  - `enable` = 0 with `req_burst` = 1 → no read issued.
  - `enable` dropped mid-burst → all 8 words complete.
  - Reset after word 3 → all outputs 0, a late readdatavalid is ignored, and the next request restarts cleanly.
- **Counter wrap:** `CNT_W` = 4, 17 single requests → `words_done` = 1.
